// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store unit shared types and constants
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load lane select with sign/zero extension
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result_o = {24'd0, byte_sel};
      F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result_o = {16'd0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - req/ack memory access with byte enables and stall
// Optional bus timeout enabled by defining LSU_BUS_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignErr,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        access, is_byte, is_half, misalign, timeout;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, align_result;

  assign access   = MemRead | MemWrite;
  assign is_byte  = (Funct3 == F3_B) || (Funct3 == F3_BU);
  assign is_half  = (Funct3 == F3_H) || (Funct3 == F3_HU);
  assign misalign = is_half ? ALUResult[0] : (!is_byte && (ALUResult[1:0] != 2'b00));

  always_comb begin
    if (is_byte) begin
      be_calc    = BE_B << ALUResult[1:0];
      wdata_calc = {4{WriteData[7:0]}};
    end else if (is_half) begin
      be_calc    = BE_H << {ALUResult[1], 1'b0};
      wdata_calc = {2{WriteData[15:0]}};
    end else begin
      be_calc    = BE_W;
      wdata_calc = WriteData;
    end
  end

  load_align u_load_align (
    .rdata_i  (mem_rdata),
    .addr_i   (ALUResult[1:0]),
    .funct3_i (Funct3),
    .result_o (align_result)
  );

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buserr_q, buserr_d;

  assign timeout = (state_q == BUSY) && !mem_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d    = (state_q == BUSY && !mem_ack) ? cnt_q + 1'b1 : '0;
    buserr_d = timeout ? 1'b1 : ((state_q == DONE) ? 1'b0 : buserr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      buserr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      buserr_q <= buserr_d;
    end
  end

  assign BusErr = buserr_q;
`else
  assign timeout = 1'b0;
  assign BusErr  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    Stall       = 1'b0;
    MisalignErr = 1'b0;
    ReadData    = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_be      = '0;
    mem_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misalign) begin
            MisalignErr = 1'b1;
          end else begin
            Stall   = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // Core is frozen, so the live inputs are the stable transaction fields.
        Stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = MemWrite;
        mem_addr  = {ALUResult[31:2], 2'b00};
        mem_be    = be_calc;
        mem_wdata = wdata_calc;
        if (mem_ack) begin
          data_d  = align_result;
          state_d = DONE;
        end else if (timeout) begin
          data_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        ReadData = data_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
